// File: rtl/vec_dot_accum_pl_if.sv
// Operand/result bundle for vec_dot_accum_pl: two packed cache lines in,
// per-line dot product and accumulated group result out.
interface vec_dot_accum_pl_if #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32
) ();
    logic                   enable;
    logic [CACHE_WIDTH-1:0] array1;
    logic [CACHE_WIDTH-1:0] array2;
    logic [DATA_WIDTH-1:0]  size_out;
    logic [DATA_WIDTH-1:0]  mul_res;
    logic                   mul_ready;
    logic [DATA_WIDTH-1:0]  res;
    logic                   ready;

    modport master (
        output enable, array1, array2, size_out,
        input  mul_res, mul_ready, res, ready
    );

    modport slave (
        input  enable, array1, array2, size_out,
        output mul_res, mul_ready, res, ready
    );
endinterface

// File: rtl/vec_dot_accum_pl.sv
// Pipelined dot-product engine: three register stages form the per-line dot
// product, a fourth sums size_out consecutive dot products into one result.
module vec_dot_accum_pl #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32
) (
    input logic               clk,
    input logic               rst,
    vec_dot_accum_pl_if.slave bus
);
    localparam int DATA_SIZE  = CACHE_WIDTH / DATA_WIDTH;
    localparam int NUM_PSUM   = 4;
    localparam int PSUM_LANES = DATA_SIZE / NUM_PSUM;

    logic [DATA_WIDTH-1:0] prod_q [DATA_SIZE];
    logic [DATA_WIDTH-1:0] prod_d [DATA_SIZE];
    logic                  v1_q, v1_d;

    logic [DATA_WIDTH-1:0] psum_q [NUM_PSUM];
    logic [DATA_WIDTH-1:0] psum_d [NUM_PSUM];
    logic                  v2_q, v2_d;

    logic [DATA_WIDTH-1:0] mul_res_q, mul_res_d;
    logic                  mul_ready_q, mul_ready_d;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH:0]   cnt_inc;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic                  group_done;

    // Data registers only load on valid cycles so idle lanes stay quiet.
    always_comb begin
        prod_d = prod_q;
        v1_d   = bus.enable;
        if (bus.enable) begin
            for (int unsigned i = 0; i < DATA_SIZE; i++) begin
                prod_d[i] = bus.array1[i*DATA_WIDTH +: DATA_WIDTH]
                          * bus.array2[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        psum_d = psum_q;
        v2_d   = v1_q;
        if (v1_q) begin
            for (int unsigned p = 0; p < NUM_PSUM; p++) begin
                psum_d[p] = '0;
                for (int unsigned l = 0; l < PSUM_LANES; l++) begin
                    psum_d[p] = psum_d[p] + prod_q[p*PSUM_LANES + l];
                end
            end
        end
    end

    always_comb begin
        mul_res_d   = mul_res_q;
        mul_ready_d = v2_q;
        if (v2_q) begin
            mul_res_d = '0;
            for (int unsigned p = 0; p < NUM_PSUM; p++) begin
                mul_res_d = mul_res_d + psum_q[p];
            end
        end
    end

    // Count compare is one bit wider so cnt+1 cannot wrap past size_out;
    // size_out of 0 then closes every group just like 1.
    always_comb begin
        cnt_inc    = {1'b0, cnt_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
        group_done = cnt_inc >= {1'b0, bus.size_out};
        acc_sum    = acc_q + mul_res_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        ready_d    = 1'b0;
        if (mul_ready_q) begin
            if (group_done) begin
                res_d   = acc_sum;
                ready_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '{default: '0};
            v1_q        <= 1'b0;
            psum_q      <= '{default: '0};
            v2_q        <= 1'b0;
            mul_res_q   <= '0;
            mul_ready_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            ready_q     <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            v1_q        <= v1_d;
            psum_q      <= psum_d;
            v2_q        <= v2_d;
            mul_res_q   <= mul_res_d;
            mul_ready_q <= mul_ready_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.mul_res   = mul_res_q;
    assign bus.mul_ready = mul_ready_q;
    assign bus.res       = res_q;
    assign bus.ready     = ready_q;
endmodule

// File: tb/tb_vec_dot_accum_pl.sv
// Bench for vec_dot_accum_pl: per-step stimulus tables replayed against a
// transaction-level model of dot products grouped by size_out.
module tb_vec_dot_accum_pl;
    localparam int CW   = 512;
    localparam int DW   = 32;
    localparam int DS   = CW / DW;
    localparam int MAXS = 128;

    typedef struct {
        int            k;
        logic [DW-1:0] d;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_dot_accum_pl_if #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW)) bus ();
    vec_dot_accum_pl #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int n_steps = 0;

    logic          st_rst [MAXS];
    logic          st_en  [MAXS];
    logic [CW-1:0] st_a   [MAXS];
    logic [CW-1:0] st_b   [MAXS];
    logic [DW-1:0] st_sz  [MAXS];
    logic          obs_mr [MAXS];
    logic          obs_rdy[MAXS];
    logic          exp_mr [MAXS];
    logic          exp_rdy[MAXS];
    logic [DW-1:0] obs_mres[MAXS];
    logic [DW-1:0] obs_res [MAXS];
    logic [DW-1:0] exp_mres[MAXS];
    logic [DW-1:0] exp_res [MAXS];
    int            pulse_step[$];
    logic [DW-1:0] pulse_res[$];

    function automatic logic [CW-1:0] lanes(input logic [DW-1:0] v);
        return {DS{v}};
    endfunction

    // Element-wise dot product, wrapping modulo 2^DW.
    function automatic logic [DW-1:0] dot(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [DW-1:0] s;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        s = '0;
        for (int i = 0; i < DS; i++) begin
            x = a[i*DW +: DW];
            y = b[i*DW +: DW];
            s = s + x * y;
        end
        return s;
    endfunction

    task automatic add(input logic r, input logic e, input logic [CW-1:0] a,
                       input logic [CW-1:0] b, input logic [DW-1:0] sz);
        st_rst[n_steps] = r;
        st_en[n_steps]  = e;
        st_a[n_steps]   = a;
        st_b[n_steps]   = b;
        st_sz[n_steps]  = sz;
        n_steps++;
    endtask

    task automatic idle(input int n, input logic [DW-1:0] sz);
        repeat (n) add(1'b0, 1'b0, '0, '0, sz);
    endtask

    // Replays the table; the model treats each enabled line as a transaction
    // whose dot product appears 2 steps later and is folded into the group
    // 3 steps later, using size_out of that step. Reset drops everything.
    task automatic run_seq();
        item_t         q[$];
        logic [DW-1:0] acc;
        logic [DW-1:0] last_mul;
        logic [DW-1:0] last_res;
        int unsigned   g;
        int unsigned   lim;
        item_t         it;
        acc = '0; last_mul = '0; last_res = '0; g = 0;
        for (int s = 0; s < n_steps; s++) begin
            rst          = st_rst[s];
            bus.enable   = st_en[s];
            bus.array1   = st_a[s];
            bus.array2   = st_b[s];
            bus.size_out = st_sz[s];
            @(posedge clk);
            #1;
            obs_mr[s]   = bus.mul_ready;
            obs_mres[s] = bus.mul_res;
            obs_rdy[s]  = bus.ready;
            obs_res[s]  = bus.res;
            exp_mr[s]  = 1'b0;
            exp_rdy[s] = 1'b0;
            if (st_rst[s]) begin
                q.delete();
                acc = '0; g = 0; last_mul = '0; last_res = '0;
            end else begin
                if (q.size() > 0 && q[0].k == s - 3) begin
                    acc = acc + q[0].d;
                    g++;
                    lim = (st_sz[s] == '0) ? 32'd1 : st_sz[s];
                    if (g >= lim) begin
                        exp_rdy[s] = 1'b1;
                        last_res   = acc;
                        acc        = '0;
                        g          = 0;
                    end
                    void'(q.pop_front());
                end
                foreach (q[j]) if (q[j].k == s - 2) begin
                    exp_mr[s] = 1'b1;
                    last_mul  = q[j].d;
                end
                if (st_en[s]) begin
                    it.k = s;
                    it.d = dot(st_a[s], st_b[s]);
                    q.push_back(it);
                end
            end
            exp_mres[s] = last_mul;
            exp_res[s]  = last_res;
        end
        pulse_step.delete();
        pulse_res.delete();
        for (int s = 0; s < n_steps; s++) begin
            if (obs_rdy[s] === 1'b1) begin
                pulse_step.push_back(s);
                pulse_res.push_back(obs_res[s]);
            end
        end
    endtask

    task automatic test_reset();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd1);
        add(1'b1, 1'b1, lanes(32'd5), lanes(32'd7), 32'd1);
        idle(5, 32'd1);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== 1'b0 || obs_mres[s] !== '0 || obs_rdy[s] !== 1'b0 || obs_res[s] !== '0) begin
                n_fail++;
                $display("FAIL reset_state step %0d: got mr=%b mres=%h rdy=%b res=%h, expected all 0",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s]);
            end
        end
    endtask

    task automatic test_single();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd1);
        add(1'b0, 1'b1, lanes(32'd2), lanes(32'd3), 32'd1);
        idle(5, 32'd1);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== exp_mr[s] || obs_mres[s] !== exp_mres[s] || obs_rdy[s] !== exp_rdy[s] || obs_res[s] !== exp_res[s]) begin
                n_fail++;
                $display("FAIL single step %0d: got mr=%b mres=%h rdy=%b res=%h, expected mr=%b mres=%h rdy=%b res=%h",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s], exp_mr[s], exp_mres[s], exp_rdy[s], exp_res[s]);
            end
        end
        n_chk++;
        if (obs_mr[3] !== 1'b1 || obs_mres[3] !== 32'd96) begin
            n_fail++;
            $display("FAIL single_mul_latency: got mr=%b mres=%0d, expected mr=1 mres=96", obs_mr[3], obs_mres[3]);
        end
        n_chk++;
        if (pulse_step.size() != 1 || pulse_step[0] != 4 || pulse_res[0] !== 32'd96) begin
            n_fail++;
            $display("FAIL single_res: got %0d pulses first step %0d res %0d, expected 1 pulse step 4 res 96",
                     pulse_step.size(), pulse_step.size() > 0 ? pulse_step[0] : -1, pulse_res.size() > 0 ? pulse_res[0] : '0);
        end
    endtask

    task automatic test_back_to_back();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd3);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd3);
        add(1'b0, 1'b1, lanes(32'd2), lanes(32'd2), 32'd3);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd3), 32'd3);
        idle(6, 32'd3);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== exp_mr[s] || obs_mres[s] !== exp_mres[s] || obs_rdy[s] !== exp_rdy[s] || obs_res[s] !== exp_res[s]) begin
                n_fail++;
                $display("FAIL b2b step %0d: got mr=%b mres=%h rdy=%b res=%h, expected mr=%b mres=%h rdy=%b res=%h",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s], exp_mr[s], exp_mres[s], exp_rdy[s], exp_res[s]);
            end
        end
        n_chk++;
        if (obs_mres[3] !== 32'd16 || obs_mres[4] !== 32'd64 || obs_mres[5] !== 32'd48) begin
            n_fail++;
            $display("FAIL b2b_mul_seq: got %0d,%0d,%0d expected 16,64,48", obs_mres[3], obs_mres[4], obs_mres[5]);
        end
        n_chk++;
        if (pulse_step.size() != 1 || pulse_step[0] != 6 || pulse_res[0] !== 32'd128) begin
            n_fail++;
            $display("FAIL b2b_res: got %0d pulses res %0d, expected 1 pulse at step 6 res 128",
                     pulse_step.size(), pulse_res.size() > 0 ? pulse_res[0] : '0);
        end
    endtask

    task automatic test_bubble();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd2);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd2);
        add(1'b0, 1'b0, lanes(32'd9), lanes(32'd9), 32'd2);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd2);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd2);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd2);
        idle(6, 32'd2);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== exp_mr[s] || obs_mres[s] !== exp_mres[s] || obs_rdy[s] !== exp_rdy[s] || obs_res[s] !== exp_res[s]) begin
                n_fail++;
                $display("FAIL bubble step %0d: got mr=%b mres=%h rdy=%b res=%h, expected mr=%b mres=%h rdy=%b res=%h",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s], exp_mr[s], exp_mres[s], exp_rdy[s], exp_res[s]);
            end
        end
        n_chk++;
        if (pulse_step.size() != 2 || pulse_step[0] != 6 || pulse_step[1] != 8 ||
            pulse_res[0] !== 32'd32 || pulse_res[1] !== 32'd32) begin
            n_fail++;
            $display("FAIL bubble_res: got %0d pulses, expected 2 pulses (steps 6,8) res 32,32", pulse_step.size());
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        a = '0; b = '0;
        a[DW-1:0] = 32'hFFFF_FFFF;
        b[DW-1:0] = 32'd2;
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd1);
        add(1'b0, 1'b1, a, b, 32'd1);
        idle(5, 32'd1);
        run_seq();
        n_chk++;
        if (obs_rdy[4] !== 1'b1 || obs_res[4] !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL wrap: got rdy=%b res=%h, expected rdy=1 res=fffffffe", obs_rdy[4], obs_res[4]);
        end
    endtask

    task automatic test_mid_reset();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd4);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd4);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd4);
        add(1'b1, 1'b0, '0, '0, 32'd4);
        repeat (4) add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd4);
        idle(6, 32'd4);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== exp_mr[s] || obs_mres[s] !== exp_mres[s] || obs_rdy[s] !== exp_rdy[s] || obs_res[s] !== exp_res[s]) begin
                n_fail++;
                $display("FAIL mid_reset step %0d: got mr=%b mres=%h rdy=%b res=%h, expected mr=%b mres=%h rdy=%b res=%h",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s], exp_mr[s], exp_mres[s], exp_rdy[s], exp_res[s]);
            end
        end
        n_chk++;
        if (pulse_step.size() != 1 || pulse_step[0] != 10 || pulse_res[0] !== 32'd64) begin
            n_fail++;
            $display("FAIL mid_reset_res: got %0d pulses res %0d, expected 1 pulse at step 10 res 64",
                     pulse_step.size(), pulse_res.size() > 0 ? pulse_res[0] : '0);
        end
    endtask

    task automatic test_size_zero();
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd0);
        add(1'b0, 1'b1, lanes(32'd1), lanes(32'd1), 32'd0);
        add(1'b0, 1'b1, lanes(32'd2), lanes(32'd2), 32'd0);
        idle(6, 32'd0);
        run_seq();
        n_chk++;
        if (pulse_step.size() != 2 || pulse_step[0] != 4 || pulse_step[1] != 5 ||
            pulse_res[0] !== 32'd16 || pulse_res[1] !== 32'd64) begin
            n_fail++;
            $display("FAIL size_zero: got %0d pulses, expected 2 pulses (steps 4,5) res 16,64", pulse_step.size());
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic          r;
        n_steps = 0;
        add(1'b1, 1'b0, '0, '0, 32'd1);
        for (int s = 0; s < 90; s++) begin
            for (int i = 0; i < DS; i++) begin
                a[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
                b[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            end
            r = ($urandom_range(0, 29) == 0);
            add(r, ($urandom_range(0, 3) != 0), a, b, 32'($urandom_range(0, 4)));
        end
        idle(6, 32'd1);
        run_seq();
        for (int s = 0; s < n_steps; s++) begin
            n_chk++;
            if (obs_mr[s] !== exp_mr[s] || obs_mres[s] !== exp_mres[s] || obs_rdy[s] !== exp_rdy[s] || obs_res[s] !== exp_res[s]) begin
                n_fail++;
                $display("FAIL random step %0d: got mr=%b mres=%h rdy=%b res=%h, expected mr=%b mres=%h rdy=%b res=%h",
                         s, obs_mr[s], obs_mres[s], obs_rdy[s], obs_res[s], exp_mr[s], exp_mres[s], exp_rdy[s], exp_res[s]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.array1   = '0;
        bus.array2   = '0;
        bus.size_out = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bubble();
        test_wrap();
        test_mid_reset();
        test_size_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_dot_accum_pl.md
Name: vec_dot_accum_pl

Overview:
- Pipelined dot-product-and-accumulate engine used by the matrix-multiply datapath.
- Each enabled cycle it takes two cache lines, each holding DATA_SIZE packed DATA_WIDTH-bit elements, and forms their element-wise dot product.
- It then sums `size_out` consecutive dot products into one result. One result is one output-matrix element when a row spans several cache lines.
- Fully pipelined: accepts one operand pair per cycle.

Parameters:
- CACHE_WIDTH, 512, width of each operand line.
- DATA_WIDTH, 32, element width and result width.
- DATA_SIZE (localparam), CACHE_WIDTH/DATA_WIDTH = 16, elements per line.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  operand pair valid this cycle.
- array1  in  CACHE_WIDTH  operand A; element i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- array2  in  CACHE_WIDTH  operand B; same packing as array1.
- size_out  in  DATA_WIDTH  number of dot products summed per result.
- mul_res  out  DATA_WIDTH  dot-product stage result.
- mul_ready  out  1  mul_res valid (one-cycle pulse per enable).
- res  out  DATA_WIDTH  accumulated result.
- ready  out  1  res valid (one-cycle pulse).

Behaviour:
- Arithmetic:
  - All products and sums are taken modulo 2^DATA_WIDTH, keeping the low DATA_WIDTH bits.
  - Signed and unsigned interpretations therefore give identical bits.
  - No saturation; overflow wraps.
- Multiply stage: three register stages; valid travels alongside the data.
  - S1: register the 16 products a[i]*b[i], truncated to DATA_WIDTH bits.
  - S2: register 4 partial sums, each summing 4 consecutive products.
  - S3: register mul_res = sum of the 4 partial sums; mul_ready = valid.
  - Latency: enable at edge t gives mul_ready=1 after edge t+3.
  - Back-to-back enables produce back-to-back mul_ready pulses with no bubbles.
  - enable=0 injects a bubble; mul_res holds its last value when mul_ready=0.
- Accumulate stage: internal acc (DATA_WIDTH bits) and cnt (DATA_WIDTH bits), updated on the edge when mul_ready=1:
  - if cnt+1 >= size_out: res <= acc + mul_res; ready <= 1; acc <= 0; cnt <= 0.
  - else: acc <= acc + mul_res; cnt <= cnt + 1; ready <= 0.
  - When mul_ready=0: ready <= 0; res, acc and cnt hold.
  - size_out = 0 behaves as 1: every product is emitted directly.
  - size_out is sampled on each mul_ready cycle. Lowering it mid-group to cnt+1 or below closes the group on the next mul_ready.
- End-to-end latency: a group's last enable at edge t produces ready=1 after edge t+4. For size_out=1 each enable gives ready four cycles later.
- Reset:
  - Clears all pipeline valids, partial sums, mul_res, mul_ready, acc, cnt, res and ready to 0.
  - Reset mid-operation discards in-flight data and any partial group.
  - enable is ignored while rst=1.
  - The first enable after rst deasserts is processed normally.
- No backpressure: the consumer must accept ready pulses as they occur.

Test Plan:
- Reset, then enable one cycle with size_out=1, all lanes of array1=2 and of array2=3 -> mul_ready after edge +3 with mul_res=96; ready after edge +4 with res=96.
- size_out=3; three consecutive enables with lane values (1,1), (2,2), (1,3) per lane -> mul_res 16, 64, 48 on consecutive cycles; a single ready pulse with res=128; ready stays 0 on the two earlier cycles.
- size_out=2; enables with a bubble (enable 1,0,1), lanes 1x1 each -> one ready with res=32; a following group of 2 starts fresh from acc=0 and gives res=32 again.
- Wrap: lane0 A=0xFFFFFFFF, B=2, other lanes 0, size_out=1 -> res=0xFFFFFFFE.
- Mid-group reset: size_out=4; two enables, then rst=1 for one cycle; then 4 enables with lanes 1x1 -> no ready from the aborted group; exactly one ready with res=64.
- size_out=0; two enables with lane values 1x1 and 2x2 -> two ready pulses with res=16 then res=64.
